// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for a 2-input gate under test.
// Walks {a,b} through 00..11, samples c, reports mismatches.
module gate_tt_sequencer #(
  parameter int DWELL  = 5,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       c_in,
  output logic       a_out,
  output logic       b_out,
  output logic [1:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask
);

  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] SAMP = CW'(SETTLE);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [1:0]    vec_q, vec_d;
  logic [3:0]    exp_q, exp_d;
  logic [3:0]    err_q, err_d;
  logic          a_q, a_d;
  logic          b_q, b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  // Next-state and registered-output logic for the sequencer FSM
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    vec_d   = vec_q;
    exp_d   = exp_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          exp_d   = expected;
          err_d   = 4'b0000;
          pass_d  = 1'b0;
          vec_d   = 2'd0;
          dwell_d = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy_d = 1'b1;
        if (dwell_q == SAMP) begin
          err_d[vec_q] = c_in ^ exp_q[vec_q];
        end
        if (dwell_q == LAST) begin
          dwell_d = '0;
          if (vec_q != 2'd3) begin
            vec_d      = vec_q + 2'd1;
            {a_d, b_d} = vec_q + 2'd1;
          end else begin
            // pass is driven alongside done so both
            // are valid in the FIN cycle
            state_d = S_FIN;
            busy_d  = 1'b0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            vec_d   = 2'd0;
            done_d  = 1'b1;
            pass_d  = (err_d == 4'b0000);
          end
        end else begin
          dwell_d = dwell_q + ONE;
        end
      end

      S_FIN: begin
        pass_d  = (err_q == 4'b0000);
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dwell_q <= '0;
      vec_q   <= 2'd0;
      exp_q   <= 4'b0000;
      err_q   <= 4'b0000;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      vec_q   <= vec_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign a_out    = a_q;
  assign b_out    = b_q;
  assign vec_idx  = vec_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_mask = err_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench for gate_tt_sequencer (DWELL=5, SETTLE=2).
// Gate under test is a selectable behavioural model.
module tb_gate_tt_sequencer;

  localparam int DW = 5;

  localparam int M_AND = 0;
  localparam int M_SA0 = 1;
  localparam int M_OR  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] expected;
  logic       c_in;
  logic       a_out;
  logic       b_out;
  logic [1:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_mask;

  int mode = M_AND;
  int checks = 0;
  int errors = 0;

  gate_tt_sequencer #(.DWELL(DW), .SETTLE(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .expected (expected),
    .c_in     (c_in),
    .a_out    (a_out),
    .b_out    (b_out),
    .vec_idx  (vec_idx),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_mask (err_mask)
  );

  always #5 clk = ~clk;

  always_comb begin
    c_in = 1'b0;
    case (mode)
      M_AND:   c_in = a_out & b_out;
      M_SA0:   c_in = 1'b0;
      M_OR:    c_in = a_out | b_out;
      default: c_in = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] obs();
    return {a_out, b_out, vec_idx, busy, done};
  endfunction

  // expected {a,b,vec,busy,done} k cycles after start edge
  function automatic logic [5:0] run_exp(input int k);
    logic [1:0] v;
    v = 2'(k / DW);
    return {v, v, 1'b1, 1'b0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    expected = 4'b1000;
    mode = M_AND;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({obs(), pass, err_mask} !== 11'd0) begin
        errors++;
        $display("FAIL reset[%0d] got %b need 0", i,
                 {obs(), pass, err_mask});
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle got %b need 00", {busy, done});
    end
  endtask

  task automatic test_run(input string nm, input int md,
                          input logic [3:0] xp,
                          input logic [3:0] xerr,
                          input logic xpass,
                          input int poke);
    mode = md;
    expected = xp;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4 * DW; k++) begin
      checks++;
      if (obs() !== run_exp(k)) begin
        errors++;
        $display("FAIL %s run[%0d] got %b need %b", nm, k,
                 obs(), run_exp(k));
      end
      if (k == poke) begin
        start = 1'b1;
        expected = 4'b0000;
      end else if (k == poke + 1) begin
        start = 1'b0;
      end
      tick();
    end
    checks++;
    if ({obs(), pass, err_mask} !== {6'b000001, xpass, xerr}) begin
      errors++;
      $display("FAIL %s fin got %b need %b", nm,
               {obs(), pass, err_mask}, {6'b000001, xpass, xerr});
    end
    tick();
    checks++;
    if ({obs(), pass, err_mask} !== {6'b000000, xpass, xerr}) begin
      errors++;
      $display("FAIL %s idle got %b need %b", nm,
               {obs(), pass, err_mask}, {6'b000000, xpass, xerr});
    end
    expected = xp;
  endtask

  task automatic test_golden();
    test_run("golden", M_AND, 4'b1000, 4'b0000, 1'b1, -10);
  endtask

  task automatic test_stuck0();
    test_run("stuck0", M_SA0, 4'b1000, 4'b1000, 1'b0, -10);
    repeat (3) tick();
    checks++;
    if ({busy, pass, err_mask} !== 6'b0_0_1000) begin
      errors++;
      $display("FAIL stuck0_hold got %b need 001000",
               {busy, pass, err_mask});
    end
  endtask

  task automatic test_wrong_gate();
    test_run("or_vs_and", M_OR, 4'b1000, 4'b0110, 1'b0, -10);
    test_run("or_vs_or", M_OR, 4'b1110, 4'b0000, 1'b1, -10);
  endtask

  task automatic test_ignore_start();
    test_run("restart7", M_AND, 4'b1000, 4'b0000, 1'b1, 7);
  endtask

  task automatic test_back_to_back();
    int ndone;
    logic xb;
    logic xd;
    ndone = 0;
    mode = M_AND;
    expected = 4'b1000;
    start = 1'b1;
    tick();
    for (int k = 0; k <= 50; k++) begin
      xd = (k == 20) || (k == 42);
      xb = (k < 20) || (k >= 22 && k < 42);
      if (done === 1'b1) ndone++;
      checks++;
      if ({busy, done} !== {xb, xd}) begin
        errors++;
        $display("FAIL b2b[%0d] busy/done got %b need %b", k,
                 {busy, done}, {xb, xd});
      end
      if (k == 22) begin
        checks++;
        if ({a_out, b_out, vec_idx} !== 4'b0000) begin
          errors++;
          $display("FAIL b2b_vec00 got %b need 0000",
                   {a_out, b_out, vec_idx});
        end
      end
      if (k == 42) begin
        checks++;
        if ({pass, err_mask} !== 5'b1_0000) begin
          errors++;
          $display("FAIL b2b_result got %b need 10000",
                   {pass, err_mask});
        end
      end
      if (k == 23) start = 1'b0;
      tick();
    end
    checks++;
    if (ndone != 2) begin
      errors++;
      $display("FAIL b2b_ndone got %0d need 2", ndone);
    end
  endtask

  task automatic test_midrun_reset();
    int nbusy;
    int ndone;
    mode = M_OR;
    expected = 4'b1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    checks++;
    if ({vec_idx, busy, err_mask} !== 7'b10_1_0010) begin
      errors++;
      $display("FAIL mid_pre got %b need 1010010",
               {vec_idx, busy, err_mask});
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({obs(), pass, err_mask} !== 11'd0) begin
      errors++;
      $display("FAIL mid_rst got %b need 0",
               {obs(), pass, err_mask});
    end
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1 || busy === 1'b1) ndone++;
      tick();
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL mid_quiet got %0d active cycles need 0", ndone);
    end
    mode = M_AND;
    start = 1'b1;
    tick();
    start = 1'b0;
    nbusy = 0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (k != 20 || {pass, err_mask} !== 5'b1_0000) begin
          errors++;
          $display("FAIL mid_rerun_done at %0d got %b need 20 10000",
                   k, {pass, err_mask});
        end
      end
      tick();
    end
    checks++;
    if (nbusy != 20 || ndone != 1) begin
      errors++;
      $display("FAIL mid_rerun busy=%0d done=%0d need 20 1",
               nbusy, ndone);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    expected = 4'b0000;
    test_reset();
    test_golden();
    test_stuck0();
    test_wrong_gate();
    test_ignore_start();
    test_back_to_back();
    test_midrun_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/gate_tt_sequencer.md
Name: gate_tt_sequencer

Overview:
Self-checking truth-table sequencer for a 2-input logic gate under test (e.g. and_gate).
- On start, drives the gate's two inputs through vectors 00, 01, 10, 11, holding each for a programmable number of cycles.
- Samples the gate output once per vector and compares it against a 4-bit expected truth table.
- Reports per-vector mismatches and an overall pass flag.
- Replaces hand-timed testbench stimulus with a reusable synthesizable controller.

Parameters:
- DWELL, 5, cycles each input vector is held; legal range is DWELL >= 2.
- SETTLE, 2, cycle index within the dwell at which c_in is sampled; legal range is 1 <= SETTLE <= DWELL-1.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  run request; sampled only in IDLE.
- expected  input  4  truth table; bit i is the expected c for vector i = {a,b}.
- c_in  input  1  output of the gate under test.
- a_out  output  1  gate input a, registered.
- b_out  output  1  gate input b, registered.
- vec_idx  output  2  index of the vector currently applied.
- busy  output  1  high while vectors are being applied.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  1 when err_mask == 0; valid from done until the next accepted start.
- err_mask  output  4  bit i set when vector i mismatched.

Behaviour:
- Clock and reset:
  - Single clock, clk. Reset is synchronous and active-low on rst_n.
  - When rst_n = 0 at a rising edge, all outputs go to 0 (a_out, b_out, vec_idx, busy, done, pass, err_mask) and the FSM goes to IDLE.
  - Reset overrides start.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - Outputs a_out = b_out = 0, busy = 0.
  - When start = 1 at an edge: latch expected into exp_q, clear err_mask to 0, clear pass to 0, set vec_idx = 0, set dwell_cnt = 0, set busy = 1, go to RUN.
- RUN:
  - {a_out, b_out} = vec_idx; both are registered and change only on vector boundaries.
  - dwell_cnt counts 0..DWELL-1.
  - When dwell_cnt == SETTLE, at that edge: err_mask[vec_idx] <= (c_in != exp_q[vec_idx]).
  - When dwell_cnt == DWELL-1: dwell_cnt wraps to 0.
    - If vec_idx < 3, vec_idx increments.
    - If vec_idx == 3, go to FIN: busy <= 0, a_out = b_out = 0, vec_idx <= 0, done <= 1.
- FIN:
  - Lasts exactly one cycle with done = 1.
  - pass <= (err_mask == 0), using the final mask including vector 3.
  - Next state is IDLE; done <= 0.
- Timing:
  - Start is accepted at edge T; vector 00 is visible after edge T.
  - busy is high for exactly 4*DWELL cycles.
  - done is high in the cycle after edge T + 4*DWELL; pass is valid in the same cycle.
  - With defaults this is 20 busy cycles.
- Held results: err_mask and pass hold their values in IDLE until the next accepted start.
- Start handling:
  - start while busy, or while in FIN, is ignored; exp_q is not re-latched.
  - start held permanently high gives back-to-back runs separated by one FIN cycle plus one IDLE cycle.
- Input stability: expected may change during a run without effect, because exp_q is used.
- Sampling assumption: c_in is treated as synchronous to clk. The DUT path a/b -> c must settle within SETTLE cycles; no synchronizer is used.
- Reset mid-run: the run is aborted, done is never pulsed, and the partial err_mask is discarded (reset to 0).

Test Plan:
All scenarios use DWELL=5, SETTLE=2 with the AND gate connected unless stated.
1. Reset: hold rst_n=0 for 3 cycles, start=1 -> all outputs 0, busy stays 0, no run until rst_n=1.
2. Golden AND run: expected=4'b1000, pulse start at T -> {a,b} is 00,01,10,11 for 5 cycles each; busy high 20 cycles; done pulses one cycle after T+20; pass=1; err_mask=0000.
3. Stuck-at-0 DUT: c_in tied 0, expected=4'b1000 -> err_mask=1000, pass=0; done timing same as scenario 2.
4. Wrong gate: OR model, expected=4'b1000 -> err_mask=0110, pass=0. Then rerun with expected=4'b1110 -> err_mask=0000, pass=1, confirming err_mask is cleared on start.
5. Start handling:
   - Pulse start again at T+7, and change expected to 0000 mid-run -> ignored; results are identical to scenario 2.
   - Hold start high continuously -> second run begins with vector 00 applied after the edge following the IDLE cycle; done pulses every 22 cycles.
6. Mid-run reset: rst_n=0 for one cycle while vec_idx=2 -> after that edge all outputs are 0 and FSM is in IDLE; no done pulse; the next start runs a full 20 cycles with correct results.
